// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: operand width and the Montgomery multiplier state encoding.
package rsa_pkg;
  localparam int WIDTH = 10;
  // Accumulator holds T < 4m, so it needs two bits above the operand width
  localparam int ACC_W = WIDTH + 2;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2
  } state_t;
endpackage

// File: rtl/mmm_step.sv
// One radix-2 Montgomery iteration: add b when the a bit is set, make the sum even with m, halve.
module mmm_step
  import rsa_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [ACC_W-1:0] acc_next
);
  logic [ACC_W:0] t_add;
  logic [ACC_W:0] t_red;

  // One spare bit keeps out-of-range operands from wrapping before the shift
  always_comb begin
    t_add    = {1'b0, acc} + (a_bit ? {{(ACC_W + 1 - WIDTH){1'b0}}, b} : '0);
    t_red    = t_add[0] ? t_add + {{(ACC_W + 1 - WIDTH){1'b0}}, m} : t_add;
    acc_next = ACC_W'(t_red >> 1);
  end
endmodule

// File: rtl/mmm_unit.sv
// Bit-serial Montgomery multiplier p = a*b*2^-WIDTH mod m; one bit of a per clock, result 11 cycles after start.
// Handshake: start is a request sampled only while busy=0; done pulses for one cycle when p is updated.
module mmm_unit
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] m_reg;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] m_ext;
  logic [ACC_W-1:0] acc_sub;
  logic [CNT_W-1:0] cnt;

  mmm_step u_step (
    .acc     (acc),
    .a_bit   (a_reg[cnt]),
    .b       (b_reg),
    .m       (m_reg),
    .acc_next(acc_next)
  );

  assign m_ext   = {{(ACC_W - WIDTH){1'b0}}, m_reg};
  assign acc_sub = acc - m_ext;
  assign busy    = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == CNT_LAST) state_next = FINAL;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      m_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      p     <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            m_reg <= m;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
        end
        FINAL: begin
          // P < 2m, so a single conditional subtract fully reduces it
          p    <= (acc >= m_ext) ? acc_sub[WIDTH-1:0] : acc[WIDTH-1:0];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
